// File: rtl/defusion_pkg.sv
// Shared widths, constants, FSM encoding and the saturating x2 conversion
// used by the de-fusion datapath.
package defusion_pkg;

  localparam int DATA_W     = 16;
  localparam int PF_W       = 32;
  localparam int NCH        = 6;
  localparam int DIV_CYCLES = 33;

  localparam logic [PF_W-1:0] P2_SAT = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    DIVP,
    DIVX,
    OUT
  } state_e;

  // Clamp a signed 33-bit quotient into the signed 16-bit state range.
  function automatic logic signed [DATA_W-1:0] sat_x2(input logic signed [32:0] v);
    if (v > 33'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -33'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/defusion_unit_seq_div33.sv
// Restoring unsigned divider: 33-bit dividend / 16-bit divisor, one quotient
// bit per cycle, exactly DIV_CYCLES iterations after the start edge.
module seq_div33
  import defusion_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [32:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [32:0] quotient_o
);

  logic [15:0] rem_q;
  logic [15:0] div_q;
  logic [32:0] quo_q;
  logic [5:0]  cnt_q;
  logic        busy_q;

  logic [16:0] shifted;
  logic [15:0] rem_d;
  logic [32:0] quo_d;

  // NOTE: every variable written here gets a value on every path, so no
  // latch can be inferred from this block.
  always_comb begin
    shifted = {rem_q, quo_q[32]};
    rem_d   = shifted[15:0];
    quo_d   = {quo_q[31:0], 1'b0};
    if (shifted >= {1'b0, div_q}) begin
      rem_d = shifted[15:0] - div_q;
      quo_d = {quo_q[31:0], 1'b1};
    end
  end

  // The final quotient is offered combinationally during the last iteration
  // so the caller can capture it and restart on the same edge.
  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == 6'd1);
  assign quotient_o = quo_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      div_q  <= divisor_i;
      quo_q  <= dividend_i;
      cnt_q  <= 6'(DIV_CYCLES);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/defusion_unit.sv
// Recovers the second contributor (x2, p2) of a fused track estimate by
// information subtraction, one element at a time over valid/ready streams.
module defusion_unit
  import defusion_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] xf,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [PF_W-1:0]   pf,
  input  logic signed [DATA_W-1:0] p1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x2,
  output logic        [PF_W-1:0]   p2,
  output logic        [2:0]        out_ch,
  output logic                     out_last,
  output logic                     out_err
);

  state_e state_q, state_d;

  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     err_q;
  logic signed [DATA_W-1:0] x2_q;
  logic        [PF_W-1:0]   p2_q;
  logic        [2:0]        ch_q;

  logic signed [DATA_W-1:0] xf_q, x1_q, p1_q;
  logic signed [PF_W-1:0]   pf_q;
  logic signed [16:0]       d_q;
  logic signed [32:0]       nx_q;

  logic signed [16:0] d_c;
  logic        [31:0] np_c;
  logic signed [32:0] nx_c;
  logic               err_c;
  logic        [32:0] nx_mag;
  logic signed [32:0] x2_full;

  logic        div_start;
  logic [32:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_busy;
  logic        div_done;
  logic [32:0] div_quo;

  logic accept;
  logic handshake;

  assign accept    = in_valid && in_ready_q;
  assign handshake = out_valid_q && out_ready;

  // Products are formed at 33 bits; in-range operands never overflow that.
  always_comb begin
    d_c    = 17'(p1_q) - $signed(pf_q[16:0]);
    np_c   = {16'b0, p1_q} * {16'b0, pf_q[15:0]};
    nx_c   = 33'(xf_q) * 33'(p1_q) - 33'(x1_q) * $signed({17'b0, pf_q[15:0]});
    err_c  = (pf_q <= 0) || (p1_q <= 0) || (pf_q >= 32'(p1_q));
    nx_mag = nx_q[32] ? 33'(-nx_q) : nx_q;
    x2_full = nx_q[32] ? -$signed(div_quo) : $signed(div_quo);
  end

  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (err_c) begin
          state_d = OUT;
        end else begin
          div_start    = 1'b1;
          div_dividend = {1'b0, np_c};
          div_divisor  = d_c[15:0];
          state_d      = DIVP;
        end
      end
      DIVP: begin
        if (div_done) begin
          div_start    = 1'b1;
          div_dividend = nx_mag;
          div_divisor  = d_q[15:0];
          state_d      = DIVX;
        end
      end
      DIVX: if (div_done) state_d = OUT;
      OUT:  if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  seq_div33 u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // NOTE: the operand latches are reset along with the outputs so that every
  // register holds a known value out of reset, not only the visible ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      x2_q        <= '0;
      p2_q        <= '0;
      ch_q        <= '0;
      xf_q        <= '0;
      x1_q        <= '0;
      p1_q        <= '0;
      pf_q        <= '0;
      d_q         <= '0;
      nx_q        <= '0;
    end else begin
      state_q    <= state_d;
      // Ready reopens one edge after returning to IDLE.
      in_ready_q <= (state_q == IDLE) && !accept && !div_busy;

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            xf_q <= xf;
            x1_q <= x1;
            p1_q <= p1;
            pf_q <= pf;
          end
        end
        CALC: begin
          d_q   <= d_c;
          nx_q  <= nx_c;
          err_q <= err_c;
          if (err_c) begin
            p2_q <= P2_SAT;
            x2_q <= x1_q;
          end
        end
        DIVP: if (div_done) p2_q <= div_quo[31:0];
        DIVX: begin
          if (div_done) begin
            x2_q        <= sat_x2(x2_full);
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            ch_q        <= (ch_q == 3'(NCH - 1)) ? 3'd0 : ch_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x2        = x2_q;
  assign p2        = p2_q;
  assign out_ch    = ch_q;
  assign out_last  = (ch_q == 3'(NCH - 1));
  assign out_err   = err_q;

endmodule

// File: tb/tb_defusion_unit.sv
// Randomized and directed bench for defusion_unit against an arithmetic
// reference model of information subtraction.
module tb_defusion_unit;
  import defusion_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     out_ready = 1'b0;
  logic signed [DATA_W-1:0] xf = '0, x1 = '0, p1 = '0;
  logic signed [PF_W-1:0]   pf = '0;
  logic                     in_ready, out_valid, out_last, out_err;
  logic signed [DATA_W-1:0] x2;
  logic        [PF_W-1:0]   p2;
  logic        [2:0]        out_ch;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int exp_ch = 0;

  defusion_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xf        (xf),
    .x1        (x1),
    .pf        (pf),
    .p1        (p1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x2        (x2),
    .p2        (p2),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: 1/P2 = 1/Pf - 1/P1 in closed form, truncating division.
  task automatic model(input logic signed [15:0] a_xf, a_x1, a_p1,
                       input logic signed [31:0] a_pf,
                       output bit e_err, output longint e_p2, output longint e_x2);
    longint d, nx, q;
    e_err = (a_pf <= 0) || (a_p1 <= 0) || (longint'(a_pf) >= longint'(a_p1));
    if (e_err) begin
      e_p2 = 64'h7FFF_FFFF;
      e_x2 = a_x1;
    end else begin
      d    = longint'(a_p1) - longint'(a_pf);
      e_p2 = (longint'(a_p1) * longint'(a_pf)) / d;
      nx   = longint'(a_xf) * longint'(a_p1) - longint'(a_x1) * longint'(a_pf);
      q    = nx / d;
      e_x2 = (q > 32767) ? 32767 : (q < -32768) ? -32768 : q;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_x2"}, x2, 0);
    check({tag, "_p2"}, p2, 0);
    check({tag, "_out_ch"}, out_ch, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_err"}, out_err, 0);
  endtask

  task automatic send(input logic signed [15:0] a_xf, a_x1, a_p1,
                      input logic signed [31:0] a_pf);
    int n = 0;
    xf = a_xf; x1 = a_x1; p1 = a_p1; pf = a_pf;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n == 300) check("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    acc_edge = edge_cnt;
    in_valid = 1'b0;
    xf = 16'($urandom); x1 = 16'($urandom); p1 = 16'($urandom); pf = $urandom;
  endtask

  task automatic receive(input string tag, input bit e_err, input longint e_p2,
                         input longint e_x2, input int stall);
    int n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, edge_cnt - acc_edge, e_err ? 2 : 67);
    check({tag, "_err"}, out_err, e_err);
    check({tag, "_p2"}, p2, e_p2);
    check({tag, "_x2"}, x2, e_x2);
    check({tag, "_ch"}, out_ch, exp_ch);
    check({tag, "_last"}, out_last, exp_ch == NCH - 1);
    check({tag, "_in_ready"}, in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_x2"}, x2, e_x2);
      check({tag, "_stall_p2"}, p2, e_p2);
      check({tag, "_stall_ch"}, out_ch, exp_ch);
      check({tag, "_stall_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    exp_ch = (exp_ch + 1) % NCH;
  endtask

  task automatic run_vec(input string tag, input logic signed [15:0] a_xf, a_x1, a_p1,
                         input logic signed [31:0] a_pf, input int stall, input bit noise);
    bit     e_err;
    longint e_p2, e_x2;
    model(a_xf, a_x1, a_p1, a_pf, e_err, e_p2, e_x2);
    send(a_xf, a_x1, a_p1, a_pf);
    if (noise) in_valid = 1'b1;
    receive(tag, e_err, e_p2, e_x2, stall);
  endtask

  task automatic rand_vec(output logic signed [15:0] a_xf, a_x1, a_p1,
                          output logic signed [31:0] a_pf);
    int kind = $urandom_range(0, 9);
    a_xf = 16'($urandom);
    a_x1 = 16'($urandom);
    a_p1 = 16'($urandom_range(2, 32767));
    a_pf = 32'($urandom_range(1, int'(a_p1) - 1));
    if (kind == 0) a_pf = $urandom;
    if (kind == 1) a_p1 = -16'($urandom_range(0, 32767));
    if (kind == 2) a_pf = 32'(a_p1);
  endtask

  initial begin
    logic signed [15:0] r_xf, r_x1, r_p1;
    logic signed [31:0] r_pf;

    #2;
    check_zero("reset");
    @(posedge clk); #1;
    check("reset_held_ready", in_ready, 0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_ready", in_ready, 1);

    run_vec("basic",     16'sd300,    16'sd200,    16'sd100,   32'sd50,    0, 1'b0);
    run_vec("negative",  -16'sd300,   -16'sd200,   16'sd100,   32'sd50,    0, 1'b1);
    run_vec("trunc",     -16'sd1,     -16'sd2,     16'sd7,     32'sd3,     10, 1'b1);
    run_vec("err_equal", 16'sd9,      16'sd55,     16'sd100,   32'sd100,   0, 1'b0);
    run_vec("err_pf0",   16'sd9,      16'sd55,     16'sd100,   32'sd0,     0, 1'b1);
    run_vec("err_p1neg", 16'sd9,      16'sd55,     -16'sd5,    32'sd50,    0, 1'b0);
    run_vec("saturate",  16'sd32767,  -16'sd32768, 16'sd32767, 32'sd32766, 0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      rand_vec(r_xf, r_x1, r_p1, r_pf);
      run_vec("pre_reset", r_xf, r_x1, r_p1, r_pf, 0, 1'b0);
    end

    send(16'sd300, 16'sd200, 16'sd100, 32'sd50);
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    exp_ch = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_release_ready", in_ready, 1);

    for (int i = 0; i < 20; i++) begin
      rand_vec(r_xf, r_x1, r_p1, r_pf);
      run_vec("random", r_xf, r_x1, r_p1, r_pf, $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
